// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: single-clock UART receiver, 8N1 (8E1 when `UART_RX_PARITY_EN is defined), internal oversample tick.
// Latency: rx_valid rises one clk after the stop-bit majority decision (mid stop bit plus the 2-flop synchroniser delay).
// Backpressure: rx_data/status held while rx_valid && !rx_ready; a frame finishing then is dropped and overrun_err pulses.
module uart_rx_oversampled #(
    parameter int BAUD_DIV   = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int DIV_W  = $clog2(BAUD_DIV);
    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int MID    = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [SCNT_W-1:0] SC_LO    = SCNT_W'(MID - 1);
    localparam logic [SCNT_W-1:0] SC_MID   = SCNT_W'(MID);
    localparam logic [SCNT_W-1:0] SC_HI    = SCNT_W'(MID + 1);
    localparam logic [SCNT_W-1:0] SC_LAST  = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [SCNT_W-1:0] SC_ONE   = SCNT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic [1:0]             prime_q;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [SCNT_W-1:0]      scnt_q, scnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [1:0]             smp_q, smp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
`endif

    logic rxs;
    logic tick;
    logic at_lo, at_mid, decide, bit_end;
    logic maj;
    logic complete;

    assign rxs     = sync2_q;
    assign tick    = (div_q == DIV_LAST);
    assign at_lo   = tick && (scnt_q == SC_LO);
    assign at_mid  = tick && (scnt_q == SC_MID);
    assign decide  = tick && (scnt_q == SC_HI);
    assign bit_end = tick && (scnt_q == SC_LAST);
    // Two stored midpoint samples plus the live one at the decision tick.
    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

    // Two-flop synchroniser for the asynchronous line; idles high out of reset.
    // prime_q marks when the synchroniser holds real line samples rather than its reset value,
    // so a line held low across reset release is not mistaken for idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prime_q <= 2'b00;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    // State, counters and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT_IDLE;
            div_q   <= '0;
            scnt_q  <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            scnt_q  <= scnt_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state: tick/sample counters, midpoint sampling and frame sequencing.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        scnt_d   = scnt_q;
        bit_d    = bit_q;
        smp_d    = smp_q;
        shift_d  = shift_q;
        complete = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        // Counters sit at zero while waiting so a start edge begins a clean bit period.
        if (state_q == S_WAIT_IDLE || state_q == S_IDLE) begin
            div_d  = '0;
            scnt_d = '0;
        end else begin
            div_d = tick ? '0 : div_q + DIV_ONE;
            if (tick) begin
                scnt_d = (scnt_q == SC_LAST) ? '0 : scnt_q + SC_ONE;
            end
        end

        if (at_lo) begin
            smp_d[0] = rxs;
        end
        if (at_mid) begin
            smp_d[1] = rxs;
        end

        case (state_q)
            S_WAIT_IDLE: begin
                if (prime_q[1] && rxs) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (decide && maj) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (decide) begin
                    par_d = maj;
                end
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at the stop midpoint so a back-to-back start edge is not missed.
                if (decide) begin
                    complete = 1'b1;
                    state_d  = maj ? S_IDLE : S_WAIT_IDLE;
                end
            end
            default: begin
                state_d = S_WAIT_IDLE;
            end
        endcase
    end

    // Output register: load on completion unless still held by the consumer, which drops the frame.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        if (complete) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ferr_d  = ~maj;
`ifdef UART_RX_PARITY_EN
                perr_d  = ^{shift_q, par_q};
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;
    assign rx_busy     = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: scoreboard bench for uart_rx_oversampled (BAUD_DIV=4, OVERSAMPLE=16, 64 clk per bit).
// Stimulus serialises frames onto rx_serial and queues the byte/status a UART receiver must deliver.
// A monitor pops and compares on every rx_valid && rx_ready, and counts overrun pulses.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

    localparam int BAUD_DIV   = 4;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int BIT_CLK    = BAUD_DIV * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_serial = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun_err, rx_busy;

    uart_rx_oversampled #(
        .BAUD_DIV  (BAUD_DIV),
        .OVERSAMPLE(OVERSAMPLE),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_serial  (rx_serial),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun_err(overrun_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ovr_seen = 0;
    int   ovr_exp = 0;
    int   stop_mid = 0;
    bit   chk_lat = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    initial begin : monitor
        bit   prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                if (overrun_err) ovr_seen++;
                if (rx_valid && !prev_valid && chk_lat) begin
                    n_cmp++;
                    if ((cyc - stop_mid) < 6 || (cyc - stop_mid) > 14) begin
                        n_bad++;
                        $display("FAIL latency: rx_valid rose %0d clk after stop midpoint, expected 10 +/- 4",
                                 cyc - stop_mid);
                    end
                end
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got rx_data 0x%0h, expected no frame (t=%0t)",
                                 rx_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", 32'(rx_data), 32'(e.d));
                        check("frame_err", 32'(frame_err), 32'(e.fe));
                        check("parity_err", 32'(parity_err), 32'(e.pe));
                    end
                end
                prev_valid = rx_valid;
            end
        end
    end

    // Drive the line and hold it for len clocks; callers stay aligned 1 ns after a rising edge.
    task automatic hold_line(input logic v, input int len);
        rx_serial = v;
        repeat (len) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One UART frame; optionally queues what a correct receiver delivers for it.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                              input int blen, input bit push);
        exp_t e;
        logic pbit;
        pbit = (^d) ^ bad_par;
        e.d  = d;
        e.fe = ~stop;
        e.pe = PAR_EN & bad_par;
        if (push) exp_q.push_back(e);
        hold_line(1'b0, blen);
        for (int i = 0; i < 8; i++) hold_line(d[i], blen);
        if (PAR_EN) hold_line(pbit, blen);
        stop_mid = cyc + blen / 2;
        hold_line(stop, blen);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d frame(s) still pending after %0d clk, expected 0", name, exp_q.size(), limit);
            exp_q.delete();
        end
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not finish, expected completion within 3 ms");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int k;
        logic [7:0] rb;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rx_valid", 32'(rx_valid), 0);
        check("reset rx_data", 32'(rx_data), 0);
        check("reset frame_err", 32'(frame_err), 0);
        check("reset parity_err", 32'(parity_err), 0);
        check("reset overrun_err", 32'(overrun_err), 0);
        check("reset rx_busy", 32'(rx_busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold_line(1'b1, 2 * BIT_CLK);
        check("idle rx_busy", 32'(rx_busy), 0);

        // 1: single 0xA5 with latency measurement
        chk_lat = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, BIT_CLK, 1'b1);
        hold_line(1'b1, BIT_CLK);
        wait_drain("drain_a5", 500);
        chk_lat = 1'b0;

        // 2: short low glitch is a false start
        hold_line(1'b0, 20);
        check("glitch rx_busy high", 32'(rx_busy), 1);
        k = 0;
        while (rx_busy && k < BIT_CLK) begin
            hold_line(1'b1, 1);
            k++;
        end
        check("glitch busy returns", 32'(k < BIT_CLK), 1);
        hold_line(1'b1, 2 * BIT_CLK);

        // 3: framing error, break, recovery
        send_frame(8'h3C, 1'b0, 1'b0, BIT_CLK, 1'b1);
        hold_line(1'b0, 3 * BIT_CLK);
        wait_drain("drain_3c", 10);
        check("break rx_busy", 32'(rx_busy), 1);
        hold_line(1'b1, 2 * BIT_CLK);
        send_frame(8'h5A, 1'b1, 1'b0, BIT_CLK, 1'b1);
        hold_line(1'b1, BIT_CLK);
        wait_drain("drain_5a", 500);

        // 4: overrun while held
        rx_ready = 1'b0;
        base = ovr_seen;
        send_frame(8'h11, 1'b1, 1'b0, BIT_CLK, 1'b1);
        hold_line(1'b1, BIT_CLK);
        send_frame(8'h22, 1'b1, 1'b0, BIT_CLK, 1'b0);
        ovr_exp++;
        hold_line(1'b1, BIT_CLK / 2);
        check("overrun pulse count", 32'(ovr_seen - base), 1);
        check("held rx_data", 32'(rx_data), 32'h11);
        check("held rx_valid", 32'(rx_valid), 1);
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid falls after accept", 32'(rx_valid), 0);
        check("accept drained", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        hold_line(1'b1, BIT_CLK);

        // 5: reset during data bit 4 with the line left low
        hold_line(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) hold_line(1'b1, BIT_CLK);
        hold_line(1'b1, 20);
        reset = 1'b1;
        hold_line(1'b0, 5);
        check("midreset rx_valid", 32'(rx_valid), 0);
        check("midreset rx_busy", 32'(rx_busy), 0);
        reset = 1'b0;
        hold_line(1'b0, 12 * BIT_CLK);
        check("low after reset rx_valid", 32'(rx_valid), 0);
        check("low after reset rx_busy", 32'(rx_busy), 1);
        hold_line(1'b1, 2 * BIT_CLK);
        send_frame(8'hC3, 1'b1, 1'b0, BIT_CLK, 1'b1);
        hold_line(1'b1, BIT_CLK);
        wait_drain("drain_c3", 500);

        // 6: parity checking
        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b1, BIT_CLK, 1'b1);
            hold_line(1'b1, BIT_CLK);
            wait_drain("drain_par_bad", 500);
            send_frame(8'h07, 1'b1, 1'b0, BIT_CLK, 1'b1);
            hold_line(1'b1, BIT_CLK);
            wait_drain("drain_par_good", 500);
        end

        // Random bytes with slight baud error and random idle gaps, including back-to-back frames
        for (int n = 0; n < 14; n++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, 1'b1, 1'b0, int'($urandom_range(BIT_CLK - 1, BIT_CLK + 1)), 1'b1);
            hold_line(1'b1, int'($urandom_range(0, 40)));
        end
        hold_line(1'b1, 2 * BIT_CLK);
        wait_drain("drain_random", 2000);

        check("total overruns", 32'(ovr_seen), 32'(ovr_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
